// File: rtl/loader_pkg.sv
// Shared definitions for the instruction ROM boot loader: FSM state codes and error codes.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LEN0   = 2'd1;
    localparam logic [1:0] ERR_LENBIG = 2'd2;
    localparam logic [1:0] ERR_CSUM   = 2'd3;

endpackage

// File: rtl/byte_to_word_asm.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid fires with the 4th byte,
// while word presents the completed word combinationally.
module byte_to_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] lanes;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lanes <= '0;
        end else if (clear) begin
            cnt   <= '0;
            lanes <= '0;
        end else if (byte_valid) begin
            cnt <= cnt + 2'd1;
            case (cnt)
                2'd0:    lanes[7:0]   <= byte_data;
                2'd1:    lanes[15:8]  <= byte_data;
                2'd2:    lanes[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // The top byte never needs storing: it is on the bus in the cycle the word completes.
    assign word_valid = byte_valid && (cnt == 2'd3);
    assign word       = {byte_data, lanes};

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader: receives LEN | data words | CSUM, writes the words into the instruction ROM,
// verifies the XOR checksum and only then releases the CPU.
module inst_rom_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    input  logic              reload_i,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              cpu_run_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    state_t          state, state_nx;
    logic [1:0]      err_nx;
    logic            alive;
    logic            accept;
    logic            reload_ok;
    logic            word_valid;
    logic [31:0]     word;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] cnt_inc;
    logic [31:0]     acc;

    // alive keeps rx_ready_o low while rst is held and for the first edge after release.
    assign rx_ready_o = alive && (state == S_LEN || state == S_DATA || state == S_CSUM);
    assign accept     = rx_valid_i && rx_ready_o;
    assign reload_ok  = reload_i && (state == S_DONE || state == S_ERR);
    assign cnt_inc    = word_cnt_o + {{ADDR_W{1'b0}}, 1'b1};

    assign done_o    = (state == S_DONE);
    assign cpu_run_o = (state == S_DONE);
    assign err_o     = (state == S_ERR);

    byte_to_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload_ok),
        .byte_valid (accept),
        .byte_data  (rx_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        err_nx   = err_code_o;
        case (state)
            S_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0) begin
                        state_nx = S_ERR;
                        err_nx   = ERR_LEN0;
                    end else if (word > 32'(DEPTH)) begin
                        state_nx = S_ERR;
                        err_nx   = ERR_LENBIG;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid && cnt_inc == len_q) state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (word_valid) begin
                    if (word == acc) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ERR;
                        err_nx   = ERR_CSUM;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (reload_i) begin
                    state_nx = S_LEN;
                    err_nx   = ERR_NONE;
                end
            end
            default: state_nx = S_LEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LEN;
            err_code_o <= ERR_NONE;
            alive      <= 1'b0;
        end else begin
            state      <= state_nx;
            err_code_o <= err_nx;
            alive      <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_we_o    <= 1'b0;
            rom_waddr_o <= '0;
            rom_wdata_o <= '0;
            word_cnt_o  <= '0;
            len_q       <= '0;
            acc         <= '0;
        end else begin
            rom_we_o <= 1'b0;
            if (reload_ok) begin
                word_cnt_o <= '0;
                len_q      <= '0;
                acc        <= '0;
            end else if (word_valid && state == S_LEN) begin
                len_q <= word[ADDR_W:0];
            end else if (word_valid && state == S_DATA) begin
                rom_we_o    <= 1'b1;
                rom_waddr_o <= word_cnt_o[ADDR_W-1:0];
                rom_wdata_o <= word;
                acc         <= acc ^ word;
                word_cnt_o  <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: frames built from a word list, expected ROM writes
// and final status derived from the frame rules, randomized payloads and valid gaps.
module tb_inst_rom_loader;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              reload = 1'b0;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t        obs_q[$];
    logic [7:0] byte_q[$];

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .reload_i    (reload),
        .rom_we_o    (rom_we),
        .rom_waddr_o (rom_waddr),
        .rom_wdata_o (rom_wdata),
        .cpu_run_o   (cpu_run),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code),
        .word_cnt_o  (word_cnt)
    );

    always @(negedge clk) begin
        if (rom_we) obs_q.push_back({rom_waddr, rom_wdata});
    end

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) byte_q.push_back(8'((w >> (8 * k)) & 32'hff));
    endtask

    // Presents one byte; returns at the negedge before the posedge that accepts it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: rx_ready_o=0 after %0d cycles, required 1", guard);
            rx_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input logic [31:0] len, input logic [31:0] words[$],
                             input logic [31:0] csum_flip, input bit gaps);
        logic [31:0]     acc = 32'd0;
        logic [31:0]     csum;
        wr_t             exp_q[$];
        bit              len_ok;
        bit              exp_done;
        logic [1:0]      exp_code;
        logic [ADDR_W:0] exp_cnt;
        obs_q.delete();
        byte_q.delete();
        len_ok = (len != 32'd0) && (len <= 32'(DEPTH));
        foreach (words[i]) acc ^= words[i];
        csum = acc ^ csum_flip;
        push_word(len);
        if (len_ok) begin
            foreach (words[i]) begin
                push_word(words[i]);
                exp_q.push_back({ADDR_W'(i), words[i]});
            end
            push_word(csum);
        end
        exp_done = len_ok && (csum == acc);
        exp_code = (len == 32'd0) ? 2'd1 : (!len_ok ? 2'd2 : (exp_done ? 2'd0 : 2'd3));
        exp_cnt  = len_ok ? len[ADDR_W:0] : '0;

        foreach (byte_q[i]) send_byte(byte_q[i], gaps);
        @(negedge clk);
        rx_valid = 1'b0;

        total += 6;
        if (done !== exp_done) begin
            bad++; $display("FAIL %s done_o: got %0b want %0b", name, done, exp_done);
        end
        if (cpu_run !== exp_done) begin
            bad++; $display("FAIL %s cpu_run_o: got %0b want %0b", name, cpu_run, exp_done);
        end
        if (err !== !exp_done) begin
            bad++; $display("FAIL %s err_o: got %0b want %0b", name, err, !exp_done);
        end
        if (err_code !== exp_code) begin
            bad++; $display("FAIL %s err_code_o: got %0d want %0d", name, err_code, exp_code);
        end
        if (word_cnt !== exp_cnt) begin
            bad++; $display("FAIL %s word_cnt_o: got %0d want %0d", name, word_cnt, exp_cnt);
        end
        if (rx_ready !== 1'b0) begin
            bad++; $display("FAIL %s rx_ready_o: got %0b want 0", name, rx_ready);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s write[%0d]: got addr %0d data %h want addr %0d data %h",
                             name, i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic do_reload(input string name);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        total += 4;
        if (rx_ready !== 1'b1) begin
            bad++; $display("FAIL %s reload rx_ready_o: got %0b want 1", name, rx_ready);
        end
        if (done !== 1'b0 || err !== 1'b0 || cpu_run !== 1'b0) begin
            bad++; $display("FAIL %s reload flags: got done=%0b err=%0b run=%0b want 0 0 0",
                            name, done, err, cpu_run);
        end
        if (err_code !== 2'd0) begin
            bad++; $display("FAIL %s reload err_code_o: got %0d want 0", name, err_code);
        end
        if (word_cnt !== '0) begin
            bad++; $display("FAIL %s reload word_cnt_o: got %0d want 0", name, word_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total += 3;
        if (rx_ready !== 1'b0) begin
            bad++; $display("FAIL reset rx_ready_o: got %0b want 0", rx_ready);
        end
        if (cpu_run !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rom_we !== 1'b0) begin
            bad++; $display("FAIL reset flags: got run=%0b done=%0b err=%0b we=%0b want all 0",
                            cpu_run, done, err, rom_we);
        end
        if (word_cnt !== '0 || err_code !== 2'd0) begin
            bad++; $display("FAIL reset counters: got cnt=%0d code=%0d want 0 0", word_cnt, err_code);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rx_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release rx_ready_o: got %0b want 1", rx_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w[$] = '{32'h00000013, 32'h00100093};
        run_frame("basic", 32'd2, w, 32'd0, 1'b0);
        do_reload("basic");
    endtask

    task automatic test_len_zero();
        logic [31:0] none[$];
        logic [31:0] w[$];
        run_frame("len_zero", 32'd0, none, 32'd0, 1'b0);
        do_reload("len_zero");
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_frame("after_len_zero", 32'd3, w, 32'd0, 1'b0);
        do_reload("after_len_zero");
    endtask

    task automatic test_len_big();
        logic [31:0] none[$];
        logic [31:0] w[$];
        run_frame("len_big", 32'(DEPTH + 1), none, 32'd0, 1'b0);
        do_reload("len_big");
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        run_frame("full_image", 32'(DEPTH), w, 32'd0, 1'b0);
        total++;
        if (obs_q.size() == 0 || obs_q[obs_q.size() - 1].a !== ADDR_W'(DEPTH - 1)) begin
            bad++;
            $display("FAIL full_image last_addr: got %0d (count %0d) want %0d",
                     (obs_q.size() == 0) ? 0 : int'(obs_q[obs_q.size() - 1].a), obs_q.size(), DEPTH - 1);
        end
        do_reload("full_image");
    endtask

    task automatic test_bad_csum();
        logic [31:0] w[$] = '{32'hDEADBEEF};
        run_frame("bad_csum", 32'd1, w, 32'h00000001, 1'b0);
        do_reload("bad_csum");
    endtask

    task automatic test_gaps();
        logic [31:0] w[$] = '{32'h00000013, 32'h00100093};
        logic [31:0] r[$];
        int          n;
        run_frame("gaps_basic", 32'd2, w, 32'd0, 1'b1);
        for (int it = 0; it < 4; it++) begin
            do_reload("gaps_rand");
            r.delete();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) r.push_back($urandom);
            run_frame("gaps_rand", 32'(n), r,
                      ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0, 1'b1);
        end
        do_reload("gaps_final");
        run_frame("gaps_done", 32'd2, w, 32'd0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w[$] = '{32'h00000013, 32'h00100093};
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (cpu_run !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_from_done: got run=%0b done=%0b want 0 0", cpu_run, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        byte_q.delete();
        obs_q.delete();
        push_word(32'd2);
        push_word(w[0]);
        for (int i = 0; i < 6; i++) send_byte(byte_q[i], 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        total += 2;
        if (cpu_run !== 1'b0 || rx_ready !== 1'b0) begin
            bad++; $display("FAIL rst_midframe: got run=%0b ready=%0b want 0 0", cpu_run, rx_ready);
        end
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL rst_midframe writes: got %0d want 0", obs_q.size());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_reset", 32'd2, w, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_len_big();
        test_bad_csum();
        test_gaps();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
